// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single 1-cycle-read RAM.
// IF is read-only; LS reads and writes; each port owns a response slot.
module mem_arbiter_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             accept,
    input  logic             rsp_ready,
    input  logic [WIDTH-1:0] mem_data_o,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             open
);
    typedef enum logic [1:0] {EMPTY, INFLIGHT, HELD} state_t;

    state_t           state;
    logic [WIDTH-1:0] hold;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= EMPTY;
            hold  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) state <= INFLIGHT;
                end
                INFLIGHT: begin
                    if (rsp_ready) begin
                        state <= accept ? INFLIGHT : EMPTY;
                    end else begin
                        hold  <= mem_data_o;
                        state <= HELD;
                    end
                end
                HELD: begin
                    if (rsp_ready) state <= accept ? INFLIGHT : EMPTY;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign rsp_valid = (state != EMPTY);
    assign open      = (state == EMPTY) || (rsp_valid && rsp_ready);

    always_comb begin
        rsp_data = '0;
        unique case (1'b1)
            (state == INFLIGHT): rsp_data = mem_data_o;
            (state == HELD):     rsp_data = hold;
            default:             rsp_data = '0;
        endcase
    end
endmodule

module mem_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             if_req_valid,
    output logic             if_req_ready,
    input  logic [AW-1:0]    if_addr,
    output logic             if_rsp_valid,
    input  logic             if_rsp_ready,
    output logic [WIDTH-1:0] if_rsp_data,
    input  logic             ls_req_valid,
    output logic             ls_req_ready,
    input  logic             ls_we,
    input  logic [AW-1:0]    ls_addr,
    input  logic [WIDTH-1:0] ls_wdata,
    output logic             ls_rsp_valid,
    input  logic             ls_rsp_ready,
    output logic [WIDTH-1:0] ls_rsp_data,
    output logic             mem_write_en,
    output logic [AW-1:0]    mem_w_addr,
    output logic [WIDTH-1:0] mem_data_i,
    output logic [AW-1:0]    mem_r_addr,
    input  logic [WIDTH-1:0] mem_data_o,
    input  logic             mem_ready
);
    logic gate;
    logic if_open, ls_open;
    logic if_elig, ls_rd_elig, ls_wr_elig, ls_elig;
    logic grant_if, grant_ls;
    logic last_ls;

    // Reset also blocks grants so no write can slip through while reset_n is low.
    assign gate       = reset_n && mem_ready;
    assign if_elig    = gate && if_req_valid && if_open;
    assign ls_rd_elig = gate && ls_req_valid && !ls_we && ls_open;
    assign ls_wr_elig = gate && ls_req_valid && ls_we;
    assign ls_elig    = ls_rd_elig || ls_wr_elig;

    assign grant_if = if_elig && (!ls_elig || last_ls);
    assign grant_ls = ls_elig && (!if_elig || !last_ls);

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            last_ls <= 1'b1;
        end else if (grant_if) begin
            last_ls <= 1'b0;
        end else if (grant_ls) begin
            last_ls <= 1'b1;
        end
    end

    assign mem_write_en = grant_ls && ls_we;
    assign mem_w_addr   = ls_addr;
    assign mem_data_i   = ls_wdata;
    assign mem_r_addr   = grant_ls ? ls_addr : if_addr;

    mem_arbiter_slot #(.WIDTH(WIDTH)) u_if_slot (
        .clock      (clock),
        .reset_n    (reset_n),
        .accept     (grant_if),
        .rsp_ready  (if_rsp_ready),
        .mem_data_o (mem_data_o),
        .rsp_valid  (if_rsp_valid),
        .rsp_data   (if_rsp_data),
        .open       (if_open)
    );

    mem_arbiter_slot #(.WIDTH(WIDTH)) u_ls_slot (
        .clock      (clock),
        .reset_n    (reset_n),
        .accept     (grant_ls && !ls_we),
        .rsp_ready  (ls_rsp_ready),
        .mem_data_o (mem_data_o),
        .rsp_valid  (ls_rsp_valid),
        .rsp_data   (ls_rsp_data),
        .open       (ls_open)
    );
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-read RAM.
module tb_mem_arbiter;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
    logic [4:0] if_addr;
    logic [7:0] if_rsp_data;
    logic       ls_req_valid, ls_req_ready, ls_we, ls_rsp_valid, ls_rsp_ready;
    logic [4:0] ls_addr;
    logic [7:0] ls_wdata, ls_rsp_data;
    logic       mem_write_en, mem_ready;
    logic [4:0] mem_w_addr, mem_r_addr;
    logic [7:0] mem_data_i, mem_data_o;

    logic       preload;
    logic [7:0] ram [32];
    logic [7:0] model [32];
    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    function automatic logic [7:0] init_val(input int i);
        return (i == 3) ? 8'hA5 : 8'(8'h80 + i);
    endfunction

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) ram[i] <= init_val(i);
        end else if (mem_write_en) begin
            ram[mem_w_addr] <= mem_data_i;
        end
        mem_data_o <= ram[mem_r_addr];
    end

    mem_arbiter #(.WIDTH(8), .DEPTH(32)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_ready (if_rsp_ready),
        .if_rsp_data  (if_rsp_data),
        .ls_req_valid (ls_req_valid),
        .ls_req_ready (ls_req_ready),
        .ls_we        (ls_we),
        .ls_addr      (ls_addr),
        .ls_wdata     (ls_wdata),
        .ls_rsp_valid (ls_rsp_valid),
        .ls_rsp_ready (ls_rsp_ready),
        .ls_rsp_data  (ls_rsp_data),
        .mem_write_en (mem_write_en),
        .mem_w_addr   (mem_w_addr),
        .mem_data_i   (mem_data_i),
        .mem_r_addr   (mem_r_addr),
        .mem_data_o   (mem_data_o),
        .mem_ready    (mem_ready)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [4:0] ia, input logic ir,
                         input logic lv, input logic we, input logic [4:0] la,
                         input logic [7:0] wd, input logic lr);
        if_req_valid = iv; if_addr = ia; if_rsp_ready = ir;
        ls_req_valid = lv; ls_we = we; ls_addr = la;
        ls_wdata = wd; ls_rsp_ready = lr;
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; mem_ready = 1'b1; preload = 1'b1;
        drive(1, 3, 1, 1, 1, 7, 8'hFF, 1);
        total++; if (if_req_ready !== 1'b0) begin bad++;
            $display("FAIL rst_if_req_ready got %b want 0", if_req_ready); end
        total++; if (ls_req_ready !== 1'b0) begin bad++;
            $display("FAIL rst_ls_req_ready got %b want 0", ls_req_ready); end
        total++; if (mem_write_en !== 1'b0) begin bad++;
            $display("FAIL rst_write_en got %b want 0", mem_write_en); end
        tick; tick;
        preload = 1'b0;
        total++; if (if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b0) begin bad++;
            $display("FAIL rst_rsp_valid got %b%b want 00", if_rsp_valid, ls_rsp_valid); end
        total++; if (if_rsp_data !== 8'h00 || ls_rsp_data !== 8'h00) begin bad++;
            $display("FAIL rst_rsp_data got %h %h want 00 00", if_rsp_data, ls_rsp_data); end
        reset_n = 1'b1; mem_ready = 1'b0;
        #1;
        total++; if (if_req_ready !== 1'b0 || ls_req_ready !== 1'b0) begin bad++;
            $display("FAIL memrdy_gate got %b%b want 00", if_req_ready, ls_req_ready); end
        total++; if (mem_write_en !== 1'b0) begin bad++;
            $display("FAIL memrdy_write_en got %b want 0", mem_write_en); end
        tick;
        mem_ready = 1'b1;
        drive(0, 0, 1, 0, 0, 0, 0, 1);
    endtask

    task automatic test_single_read;
        drive(1, 3, 1, 0, 0, 0, 0, 1);
        total++; if (if_req_ready !== 1'b1) begin bad++;
            $display("FAIL single_req_ready got %b want 1", if_req_ready); end
        total++; if (mem_r_addr !== 5'd3 || mem_write_en !== 1'b0) begin bad++;
            $display("FAIL single_mem got r_addr=%0d we=%b want 3 0", mem_r_addr, mem_write_en); end
        tick;
        drive(0, 0, 1, 0, 0, 0, 0, 1);
        total++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== 8'hA5) begin bad++;
            $display("FAIL single_rsp got v=%b d=%h want 1 a5", if_rsp_valid, if_rsp_data); end
        total++; if (ls_rsp_valid !== 1'b0) begin bad++;
            $display("FAIL single_ls_quiet got %b want 0", ls_rsp_valid); end
        tick;
        total++; if (if_rsp_valid !== 1'b0) begin bad++;
            $display("FAIL single_drain got %b want 0", if_rsp_valid); end
    endtask

    task automatic test_alternate;
        logic       exp_if;
        logic       prev_if;
        logic [4:0] prev_addr;
        exp_if = 1'b0;
        prev_if = 1'b0;
        prev_addr = '0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 5'(i), 1, 1, 0, 5'(16 + i), 0, 1);
            total++; if (if_req_ready !== exp_if || ls_req_ready !== !exp_if) begin bad++;
                $display("FAIL alt_grant[%0d] got if=%b ls=%b want if=%b", i,
                         if_req_ready, ls_req_ready, exp_if); end
            if (i > 0) begin
                total++;
                if (prev_if) begin
                    if (if_rsp_valid !== 1'b1 || if_rsp_data !== model[prev_addr]
                        || ls_rsp_valid !== 1'b0) begin bad++;
                        $display("FAIL alt_if_rsp[%0d] got v=%b d=%h want 1 %h", i,
                                 if_rsp_valid, if_rsp_data, model[prev_addr]); end
                end else begin
                    if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== model[prev_addr]
                        || if_rsp_valid !== 1'b0) begin bad++;
                        $display("FAIL alt_ls_rsp[%0d] got v=%b d=%h want 1 %h", i,
                                 ls_rsp_valid, ls_rsp_data, model[prev_addr]); end
                end
            end
            prev_if = exp_if;
            prev_addr = exp_if ? 5'(i) : 5'(16 + i);
            exp_if = !exp_if;
            tick;
        end
        drive(0, 0, 1, 0, 0, 0, 0, 1);
        total++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== model[prev_addr]) begin bad++;
            $display("FAIL alt_last got v=%b d=%h want 1 %h", if_rsp_valid, if_rsp_data,
                     model[prev_addr]); end
        tick;
    endtask

    task automatic test_write_read;
        drive(0, 0, 1, 1, 1, 7, 8'h3C, 1);
        total++; if (ls_req_ready !== 1'b1 || mem_write_en !== 1'b1) begin bad++;
            $display("FAIL wr_accept got rdy=%b we=%b want 1 1", ls_req_ready, mem_write_en); end
        total++; if (mem_w_addr !== 5'd7 || mem_data_i !== 8'h3C) begin bad++;
            $display("FAIL wr_drive got a=%0d d=%h want 7 3c", mem_w_addr, mem_data_i); end
        model[7] = 8'h3C;
        tick;
        drive(0, 0, 1, 1, 0, 7, 0, 1);
        total++; if (ls_req_ready !== 1'b1 || mem_write_en !== 1'b0 || mem_r_addr !== 5'd7) begin
            bad++;
            $display("FAIL rd_accept got rdy=%b we=%b a=%0d want 1 0 7", ls_req_ready,
                     mem_write_en, mem_r_addr); end
        total++; if (ls_rsp_valid !== 1'b0) begin bad++;
            $display("FAIL wr_no_rsp got %b want 0", ls_rsp_valid); end
        tick;
        drive(0, 0, 1, 0, 0, 0, 0, 1);
        total++; if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== 8'h3C) begin bad++;
            $display("FAIL wr_rd_order got v=%b d=%h want 1 3c", ls_rsp_valid, ls_rsp_data); end
        tick;
    endtask

    task automatic test_hold;
        drive(1, 5, 0, 0, 0, 0, 0, 1);
        total++; if (if_req_ready !== 1'b1) begin bad++;
            $display("FAIL hold_accept got %b want 1", if_req_ready); end
        tick;
        for (int j = 0; j < 3; j++) begin
            drive(1, 6, 0, 1, 0, 5'(10 + j), 0, 1);
            total++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== model[5]) begin bad++;
                $display("FAIL hold_data[%0d] got v=%b d=%h want 1 %h", j, if_rsp_valid,
                         if_rsp_data, model[5]); end
            total++; if (if_req_ready !== 1'b0 || ls_req_ready !== 1'b1) begin bad++;
                $display("FAIL hold_grant[%0d] got if=%b ls=%b want 0 1", j,
                         if_req_ready, ls_req_ready); end
            if (j > 0) begin
                total++;
                if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== model[10 + j - 1]) begin bad++;
                    $display("FAIL hold_ls_rsp[%0d] got v=%b d=%h want 1 %h", j,
                             ls_rsp_valid, ls_rsp_data, model[10 + j - 1]); end
            end
            tick;
        end
        drive(1, 6, 1, 1, 0, 13, 0, 1);
        total++; if (if_rsp_data !== model[5] || ls_rsp_data !== model[12]) begin bad++;
            $display("FAIL hold_release got if=%h ls=%h want %h %h", if_rsp_data,
                     ls_rsp_data, model[5], model[12]); end
        total++; if (if_req_ready !== 1'b1 || ls_req_ready !== 1'b0) begin bad++;
            $display("FAIL hold_rr got if=%b ls=%b want 1 0", if_req_ready, ls_req_ready); end
        tick;
        drive(0, 0, 1, 0, 0, 0, 0, 1);
        total++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== model[6]
                     || ls_rsp_valid !== 1'b0) begin bad++;
            $display("FAIL hold_next got v=%b d=%h lsv=%b want 1 %h 0", if_rsp_valid,
                     if_rsp_data, ls_rsp_valid, model[6]); end
        tick;
    endtask

    task automatic test_write_pending;
        logic [7:0] old;
        old = model[2];
        drive(0, 0, 1, 1, 0, 2, 0, 0);
        total++; if (ls_req_ready !== 1'b1) begin bad++;
            $display("FAIL wp_read got %b want 1", ls_req_ready); end
        tick;
        drive(0, 0, 1, 1, 1, 2, 8'h77, 0);
        total++; if (ls_req_ready !== 1'b1 || mem_write_en !== 1'b1) begin bad++;
            $display("FAIL wp_write got rdy=%b we=%b want 1 1", ls_req_ready, mem_write_en); end
        model[2] = 8'h77;
        tick;
        drive(0, 0, 1, 1, 0, 2, 0, 0);
        total++; if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== old || ls_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL wp_held got v=%b d=%h rdy=%b want 1 %h 0", ls_rsp_valid,
                     ls_rsp_data, ls_req_ready, old); end
        tick;
        drive(0, 0, 1, 1, 0, 2, 0, 1);
        total++; if (ls_rsp_data !== old || ls_req_ready !== 1'b1) begin bad++;
            $display("FAIL wp_release got d=%h rdy=%b want %h 1", ls_rsp_data,
                     ls_req_ready, old); end
        tick;
        drive(0, 0, 1, 0, 0, 0, 0, 1);
        total++; if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== 8'h77) begin bad++;
            $display("FAIL wp_new got v=%b d=%h want 1 77", ls_rsp_valid, ls_rsp_data); end
        tick;
    endtask

    task automatic test_stream;
        for (int k = 0; k < 32; k++) begin
            drive(1, 5'(k), 1, 0, 0, 0, 0, 1);
            total++; if (if_req_ready !== 1'b1) begin bad++;
                $display("FAIL stream_ready[%0d] got %b want 1", k, if_req_ready); end
            if (k > 0) begin
                total++;
                if (if_rsp_valid !== 1'b1 || if_rsp_data !== model[k - 1]) begin bad++;
                    $display("FAIL stream_rsp[%0d] got v=%b d=%h want 1 %h", k - 1,
                             if_rsp_valid, if_rsp_data, model[k - 1]); end
            end
            tick;
        end
        drive(0, 0, 1, 0, 0, 0, 0, 1);
        total++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== model[31]) begin bad++;
            $display("FAIL stream_last got v=%b d=%h want 1 %h", if_rsp_valid,
                     if_rsp_data, model[31]); end
        tick;
    endtask

    task automatic test_reset_held;
        drive(1, 9, 0, 0, 0, 0, 0, 1);
        total++; if (if_req_ready !== 1'b1) begin bad++;
            $display("FAIL rh_accept got %b want 1", if_req_ready); end
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick;
        reset_n = 1'b0;
        drive(0, 0, 0, 1, 1, 4, 8'h11, 1);
        total++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== model[9]) begin bad++;
            $display("FAIL rh_held got v=%b d=%h want 1 %h", if_rsp_valid, if_rsp_data,
                     model[9]); end
        total++; if (mem_write_en !== 1'b0 || ls_req_ready !== 1'b0) begin bad++;
            $display("FAIL rh_no_write got we=%b rdy=%b want 0 0", mem_write_en,
                     ls_req_ready); end
        tick;
        reset_n = 1'b1;
        drive(1, 3, 1, 1, 0, 4, 0, 1);
        total++; if (if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b0
                     || if_rsp_data !== 8'h00) begin bad++;
            $display("FAIL rh_dropped got v=%b%b d=%h want 00 00", if_rsp_valid,
                     ls_rsp_valid, if_rsp_data); end
        total++; if (if_req_ready !== 1'b1 || ls_req_ready !== 1'b0) begin bad++;
            $display("FAIL rh_rr got if=%b ls=%b want 1 0", if_req_ready, ls_req_ready); end
        tick;
        drive(0, 0, 1, 0, 0, 0, 0, 1);
        total++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== model[3]) begin bad++;
            $display("FAIL rh_after got v=%b d=%h want 1 %h", if_rsp_valid, if_rsp_data,
                     model[3]); end
        total++; if (ram[4] !== model[4]) begin bad++;
            $display("FAIL rh_ram4 got %h want %h", ram[4], model[4]); end
        tick;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = init_val(i);
        test_reset;
        test_single_read;
        test_alternate;
        test_write_read;
        test_hold;
        test_write_pending;
        test_stream;
        test_reset_held;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
